// File: rtl/rv_pkg.sv
// Shared RV32 front-end definitions: datapath width, canonical NOP and
// the {pc, inst} entry carried from fetch to decode.
package rv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a synchronous clear.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != CW'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end

    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited requests to inst memory, in-order
// responses buffered as {pc, inst} for decode; redirects flush and drop stale data.
module fetch_queue
    import rv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   r_discard;

    logic [CW-1:0]   w_fifo_cnt;
    logic [CW-1:0]   w_outstanding;
    logic [CW:0]     w_used;
    logic [XLEN-1:0] w_req_pc;
    logic            w_push;
    logic            w_pop;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    // Every slot is reserved at request time, so a response always fits.
    assign w_used    = {1'b0, w_fifo_cnt} + {1'b0, w_outstanding};
    assign imem_req  = !rst && !redirect && (w_used < (CW+1)'(DEPTH));
    assign imem_addr = r_fetch_pc;

    assign w_push       = imem_rvalid && (r_discard == '0) && !redirect;
    assign w_pop        = out_valid && out_ready && !redirect;
    assign w_push_entry = '{pc: w_req_pc, inst: imem_rdata};

    assign out_valid = !rst && (w_fifo_cnt != '0);
    assign out_pc    = out_valid ? w_head.pc   : '0;
    assign out_inst  = out_valid ? w_head.inst : '0;

    always_ff @(posedge clk) begin
        if (rst)                r_fetch_pc <= RESET_PC;
        else if (redirect)      r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        else if (imem_req)      r_fetch_pc <= r_fetch_pc + 32'd4;
    end

    // A response landing in the redirect cycle is already dropped, so it is not counted.
    always_ff @(posedge clk) begin
        if (rst)
            r_discard <= '0;
        else if (redirect)
            r_discard <= w_outstanding - CW'(imem_rvalid);
        else if (imem_rvalid && (r_discard != '0))
            r_discard <= r_discard - 1'b1;
    end

    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_push  (imem_req),
        .i_data  (r_fetch_pc),
        .i_pop   (imem_rvalid),
        .o_data  (w_req_pc),
        .o_count (w_outstanding)
    );

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entry_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (redirect),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_fifo_cnt)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order memory model with random latency
// plus a queue-based reference of the fetch stream.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;

    req_t        m_out[$];
    ent_t        m_fifo[$];
    mem_t        mem_q[$];
    logic [31:0] m_pc;
    int          lat_min = 1;
    int          lat_max = 1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        obs_valid, obs_req;
    logic [31:0] obs_pc, obs_inst, obs_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock: drive inputs after the edge, check and advance the model at negedge.
    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
        req_t q;
        ent_t e;
        bit   exp_valid, exp_req;
        @(posedge clk); #1;
        cyc++;
        rst = r; redirect = rd; redirect_pc = rpc; out_ready = rdy;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (!r && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        @(negedge clk);
        obs_valid = out_valid; obs_req = imem_req;
        obs_pc = out_pc; obs_inst = out_inst; obs_addr = imem_addr;
        if (r) begin
            n_checks++;
            if (imem_req !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'd0 || out_inst !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d req=%b valid=%b pc=%h inst=%h, required 0 0 0 0",
                         cyc, imem_req, out_valid, out_pc, out_inst);
            end
            m_fifo.delete(); m_out.delete(); mem_q.delete();
            m_pc = RESET_PC;
        end else begin
            exp_valid = (m_fifo.size() != 0);
            exp_req   = !rd && (m_fifo.size() + m_out.size() < DEPTH);
            n_checks++;
            if (out_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid);
            end else if (exp_valid) begin
                n_checks++;
                if (out_pc !== m_fifo[0].pc || out_inst !== m_fifo[0].inst) begin
                    n_fail++;
                    $display("FAIL head cyc=%0d pc=%h inst=%h exp pc=%h inst=%h",
                             cyc, out_pc, out_inst, m_fifo[0].pc, m_fifo[0].inst);
                end
            end
            n_checks++;
            if (imem_req !== exp_req) begin
                n_fail++;
                $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req);
            end else if (exp_req) begin
                n_checks++;
                if (imem_addr !== m_pc) begin
                    n_fail++;
                    $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_pc);
                end
            end
            if (imem_req === 1'b1)
                mem_q.push_back('{imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
            if (exp_valid && rdy && !rd) void'(m_fifo.pop_front());
            if (imem_rvalid) begin
                if (m_out.size() == 0) begin
                    n_fail++;
                    $display("FAIL underflow cyc=%0d response with nothing outstanding", cyc);
                end else begin
                    q = m_out.pop_front();
                    if (!q.stale && !rd) begin
                        e.pc = q.pc; e.inst = mem_word(q.pc);
                        m_fifo.push_back(e);
                    end
                end
            end
            if (m_fifo.size() > DEPTH) begin
                n_fail++;
                $display("FAIL overflow cyc=%0d entries=%0d", cyc, m_fifo.size());
            end
            if (rd) begin
                m_fifo.delete();
                foreach (m_out[i]) m_out[i].stale = 1'b1;
                m_pc = {rpc[31:2], 2'b00};
            end else if (exp_req) begin
                q.pc = m_pc; q.stale = 1'b0;
                m_out.push_back(q);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_reset();
        lat_min = 1; lat_max = 1;
        do_reset(3);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL first_req req=%b addr=%h exp 1 %h", obs_req, obs_addr, RESET_PC);
        end
    endtask

    task automatic test_first_fetch();
        lat_min = 1; lat_max = 1;
        do_reset(2);
        for (int k = 0; k <= 5; k++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1);
            if (k >= 2) begin
                n_checks++;
                if (obs_valid !== 1'b1 || obs_pc !== 32'((k - 2) * 4)) begin
                    n_fail++;
                    $display("FAIL first_stream k=%0d valid=%b pc=%h exp 1 %h", k, obs_valid, obs_pc, (k - 2) * 4);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int nreq, npop;
        lat_min = 2; lat_max = 2;
        do_reset(2);
        nreq = 0; npop = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            if (obs_req) nreq++;
        end
        n_checks++;
        if (nreq != DEPTH || obs_req !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_requests got=%0d last_req=%b exp %0d 0", nreq, obs_req, DEPTH);
        end
        n_checks++;
        if (obs_valid !== 1'b1 || obs_pc !== 32'd0 || obs_inst !== mem_word(32'd0)) begin
            n_fail++;
            $display("FAIL bp_stable valid=%b pc=%h inst=%h exp 1 0 %h", obs_valid, obs_pc, obs_inst, mem_word(32'd0));
        end
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1);
            if (obs_valid) npop++;
        end
        n_checks++;
        if (npop < DEPTH) begin
            n_fail++;
            $display("FAIL bp_drain pops=%0d exp>=%0d", npop, DEPTH);
        end
    endtask

    task automatic test_redirect();
        bit          seen;
        logic [31:0] first_pc;
        int          nstale;
        lat_min = 3; lat_max = 3;
        do_reset(2);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        n_checks++;
        if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_cycle req=%b valid=%b exp 0 0", obs_req, obs_valid);
        end
        seen = 0; first_pc = '0; nstale = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1);
            if (obs_valid && !seen) begin seen = 1; first_pc = obs_pc; end
            if (obs_valid && obs_pc < 32'h100) nstale++;
        end
        n_checks++;
        if (!seen || first_pc !== 32'h0000_0100 || nstale != 0) begin
            n_fail++;
            $display("FAIL redir_target seen=%0d pc=%h stale=%0d exp 1 00000100 0", seen, first_pc, nstale);
        end
    endtask

    task automatic test_redirect_full_pop();
        lat_min = 1; lat_max = 1;
        do_reset(2);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
        n_checks++;
        if (obs_req !== 1'b0 || obs_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_state req=%b valid=%b exp 0 1", obs_req, obs_valid);
        end
        step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        n_checks++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL full_redir valid=%b req=%b addr=%h exp 0 1 00000200", obs_valid, obs_req, obs_addr);
        end
    endtask

    task automatic test_wrap();
        lat_min = 1; lat_max = 1;
        do_reset(2);
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        n_checks++;
        if (obs_addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_pre addr=%h exp fffffffc", obs_addr);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1);
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_post req=%b addr=%h exp 1 00000000", obs_req, obs_addr);
        end
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic test_random();
        logic        r, rd, rdy;
        logic [31:0] rpc;
        lat_min = 1; lat_max = 4;
        do_reset(2);
        for (int k = 0; k < 3000; k++) begin
            r   = ($urandom_range(499, 0) == 0);
            rd  = !r && ($urandom_range(15, 0) == 0);
            rdy = ($urandom_range(3, 0) != 0);
            rpc = $urandom;
            if ($urandom_range(7, 0) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            step(r, rd, rpc, rdy);
        end
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        m_pc = RESET_PC;
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect();
        test_redirect_full_pop();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
